// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART RX/TX byte streams seen by the memory/IO responder.
// Handshake rules for the UART streams: a byte moves on a rising clock edge
// exactly when valid and ready are both high in that cycle. valid never waits
// for ready. The CPU bus has no handshake. It presents one address every
// cycle, and the responder always completes that access.
interface mem_io_responder_if;
  logic [31:0] mem_a_in;
  logic        mem_wr_in;
  logic [7:0]  mem_wdata_in;
  logic [7:0]  mem_rdata_out;
  logic        io_buffer_full_out;
  logic        rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        rx_ready_out;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic        tx_ready_in;
  logic        program_stop_out;
  logic        tx_overflow_out;

  // Responder side
  modport slave (
    input  mem_a_in, mem_wr_in, mem_wdata_in, rx_valid_in, rx_data_in, tx_ready_in,
    output mem_rdata_out, io_buffer_full_out, rx_ready_out, tx_valid_out,
           tx_data_out, program_stop_out, tx_overflow_out
  );

  // CPU / UART side
  modport master (
    output mem_a_in, mem_wr_in, mem_wdata_in, rx_valid_in, rx_data_in, tx_ready_in,
    input  mem_rdata_out, io_buffer_full_out, rx_ready_out, tx_valid_out,
           tx_data_out, program_stop_out, tx_overflow_out
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus. It contains a byte RAM and an IO
// page at addr[17:16]==2'b11. The IO page holds the UART RX/TX FIFOs, a
// free-running cycle counter with a coherent snapshot, and the sticky
// program-stop and TX-overflow flags.
// Reads return data one cycle after the address is sampled. Writes complete in
// the same cycle.
module mem_io_responder #(
  parameter int MEM_BYTES = 131072,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16,
  parameter int TX_MARGIN = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  mem_io_responder_if.slave bus
);
  localparam int RAM_AW = $clog2(MEM_BYTES);
  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int TX_AW  = $clog2(TX_DEPTH);

  localparam logic [18:0]      MEM_LIM   = 19'(MEM_BYTES);
  localparam logic [RX_AW:0]   RX_FULL   = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_FULL   = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [TX_AW:0]   TX_THR    = (TX_AW + 1)'(TX_DEPTH - TX_MARGIN);
  localparam logic [RX_AW-1:0] RX_PTR_1  = 1;
  localparam logic [TX_AW-1:0] TX_PTR_1  = 1;
  localparam logic [17:0]      A_DATA    = 18'h30000;
  localparam logic [17:0]      A_CNT0    = 18'h30004;
  localparam logic [17:0]      A_CNT1    = 18'h30005;
  localparam logic [17:0]      A_CNT2    = 18'h30006;
  localparam logic [17:0]      A_CNT3    = 18'h30007;

  logic [7:0]       r_ram [0:MEM_BYTES-1];
  logic [7:0]       r_rx_mem [0:RX_DEPTH-1];
  logic [7:0]       r_tx_mem [0:TX_DEPTH-1];
  logic [RX_AW-1:0] r_rx_rd, r_rx_wr;
  logic [TX_AW-1:0] r_tx_rd, r_tx_wr;
  logic [RX_AW:0]   r_rx_cnt;
  logic [TX_AW:0]   r_tx_cnt;
  logic [7:0]       r_rdata;
  logic [31:0]      r_cnt;
  logic [23:0]      r_snap;
  logic             r_stop, r_ovf, r_iobuf;

  logic [17:0]       w_a;
  logic              w_wr, w_is_io, w_is_ram;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_rx_ready, w_rx_push, w_rx_pop;
  logic              w_tx_valid, w_tx_pop, w_tx_req, w_tx_room, w_tx_push, w_ovf_set;
  logic              w_wr_data_nz, w_wr_stop, w_rd_cnt0;
  logic [7:0]        w_tx_din;
  logic [RX_AW:0]    w_rx_cnt_nxt;
  logic [TX_AW:0]    w_tx_cnt_nxt;
  logic [7:0]        w_rdata_nxt;

  // Only addr[17:0] is decoded. The IO page takes priority over the RAM range.
  assign w_a       = bus.mem_a_in[17:0];
  assign w_wr      = bus.mem_wr_in;
  assign w_is_io   = (w_a[17:16] == 2'b11);
  assign w_is_ram  = !w_is_io && ({1'b0, w_a} < MEM_LIM);
  assign w_ram_idx = w_a[RAM_AW-1:0];

  // RX FIFO: the UART pushes through ready. A CPU read of the data port pops
  // the head, but only when the FIFO holds a byte.
  assign w_rx_ready   = (r_rx_cnt != RX_FULL);
  assign w_rx_push    = bus.rx_valid_in && w_rx_ready;
  assign w_rx_pop     = !w_wr && (w_a == A_DATA) && (r_rx_cnt != '0);
  assign w_rx_cnt_nxt = r_rx_cnt + {{RX_AW{1'b0}}, w_rx_push} - {{RX_AW{1'b0}}, w_rx_pop};

  // TX FIFO: a pop in the same cycle frees a slot, so a write into a full FIFO
  // is still accepted when the UART drains a byte at that edge.
  assign w_tx_valid   = (r_tx_cnt != '0);
  assign w_tx_pop     = w_tx_valid && bus.tx_ready_in;
  assign w_wr_data_nz = w_wr && (w_a == A_DATA) && (bus.mem_wdata_in != 8'h00);
  assign w_wr_stop    = w_wr && (w_a == A_CNT0);
  assign w_tx_req     = w_wr_data_nz || w_wr_stop;
  assign w_tx_room    = (r_tx_cnt != TX_FULL) || w_tx_pop;
  assign w_tx_push    = w_tx_req && w_tx_room;
  assign w_ovf_set    = w_wr_data_nz && !w_tx_room;
  assign w_tx_din     = w_wr_stop ? 8'h00 : bus.mem_wdata_in;
  assign w_tx_cnt_nxt = r_tx_cnt + {{TX_AW{1'b0}}, w_tx_push} - {{TX_AW{1'b0}}, w_tx_pop};

  assign w_rd_cnt0 = !w_wr && (w_a == A_CNT0);

  // Select the read byte for the current address. Writes and unmapped reads return 0x00.
  always_comb begin
    w_rdata_nxt = 8'h00;
    if (!w_wr) begin
      if (w_is_ram) begin
        w_rdata_nxt = r_ram[w_ram_idx];
      end else if (w_is_io) begin
        case (w_a)
          A_DATA:  w_rdata_nxt = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rd] : 8'h00;
          A_CNT0:  w_rdata_nxt = r_cnt[7:0];
          A_CNT1:  w_rdata_nxt = r_snap[7:0];
          A_CNT2:  w_rdata_nxt = r_snap[15:8];
          A_CNT3:  w_rdata_nxt = r_snap[23:16];
          default: w_rdata_nxt = 8'h00;
        endcase
      end
    end
  end

  // RAM and FIFO storage. These have no reset, because their contents are
  // only meaningful behind the pointers.
  always_ff @(posedge clk_in) begin
    if (w_wr && w_is_ram) r_ram[w_ram_idx] <= bus.mem_wdata_in;
    if (w_rx_push)        r_rx_mem[r_rx_wr] <= bus.rx_data_in;
    if (w_tx_push)        r_tx_mem[r_tx_wr] <= w_tx_din;
  end

  // Control state: read data, FIFO pointers and counts, counter, snapshot, and flags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rdata  <= 8'h00;
      r_rx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_cnt <= '0;
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
      r_cnt    <= 32'h0;
      r_snap   <= 24'h0;
      r_stop   <= 1'b0;
      r_ovf    <= 1'b0;
      r_iobuf  <= 1'b0;
    end else begin
      r_rdata  <= w_rdata_nxt;
      r_cnt    <= r_cnt + 32'd1;
      r_rx_cnt <= w_rx_cnt_nxt;
      r_tx_cnt <= w_tx_cnt_nxt;
      r_iobuf  <= (w_tx_cnt_nxt >= TX_THR);
      if (w_rd_cnt0) r_snap  <= r_cnt[31:8];
      if (w_rx_push) r_rx_wr <= r_rx_wr + RX_PTR_1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_PTR_1;
      if (w_tx_push) r_tx_wr <= r_tx_wr + TX_PTR_1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_PTR_1;
      if (w_wr_stop) r_stop  <= 1'b1;
      if (w_ovf_set) r_ovf   <= 1'b1;
    end
  end

  assign bus.mem_rdata_out      = r_rdata;
  assign bus.io_buffer_full_out = r_iobuf;
  assign bus.rx_ready_out       = w_rx_ready;
  assign bus.tx_valid_out       = w_tx_valid;
  assign bus.tx_data_out        = r_tx_mem[r_tx_rd];
  assign bus.program_stop_out   = r_stop;
  assign bus.tx_overflow_out    = r_ovf;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder. A queue/array model of the responder is checked
// every cycle, and the model is pinned by directed cases with literal
// expectations. Random CPU/UART traffic follows the directed cases.
module tb_mem_io_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_on = 1'b0;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state: RAM contents written so far, FIFO queues, counter, flags.
  logic [7:0]  m_ram [int];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] m_cnt;
  logic [23:0] m_snap;
  bit          m_stop, m_ovf;
  logic [7:0]  exp_rd;
  bit          exp_rd_vld;
  logic [17:0] m_a;
  int          m_rx_pre;
  bit          m_tx_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: applies each sampled access as whole-byte queue/array operations.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q.delete();
      tx_q.delete();
      m_cnt = 0; m_snap = 0; m_stop = 0; m_ovf = 0;
      exp_rd = 0; exp_rd_vld = 1;
    end else begin
      m_a      = bus.mem_a_in[17:0];
      m_rx_pre = rx_q.size();
      m_tx_pop = (tx_q.size() > 0) && bus.tx_ready_in;
      exp_rd = 8'h00;
      exp_rd_vld = 1;
      if (m_tx_pop) void'(tx_q.pop_front());
      if (!bus.mem_wr_in) begin
        if (m_a < 18'h20000) begin
          if (m_ram.exists(int'(m_a))) exp_rd = m_ram[int'(m_a)];
          else exp_rd_vld = 0;
        end else if (m_a == 18'h30000) begin
          if (rx_q.size() > 0) exp_rd = rx_q.pop_front();
        end else if (m_a == 18'h30004) begin
          exp_rd = m_cnt[7:0];
          m_snap = m_cnt[31:8];
        end else if (m_a == 18'h30005) exp_rd = m_snap[7:0];
        else if (m_a == 18'h30006) exp_rd = m_snap[15:8];
        else if (m_a == 18'h30007) exp_rd = m_snap[23:16];
      end else begin
        exp_rd_vld = 0;
        if (m_a < 18'h20000) m_ram[int'(m_a)] = bus.mem_wdata_in;
        if (m_a == 18'h30000 && bus.mem_wdata_in != 8'h00) begin
          if (tx_q.size() < 16) tx_q.push_back(bus.mem_wdata_in);
          else m_ovf = 1;
        end
        if (m_a == 18'h30004) begin
          m_stop = 1;
          if (tx_q.size() < 16) tx_q.push_back(8'h00);
        end
      end
      if (bus.rx_valid_in && m_rx_pre < 16) rx_q.push_back(bus.rx_data_in);
      m_cnt = m_cnt + 1;
    end
  end

  // Compare on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      if (exp_rd_vld) check("rdata", bus.mem_rdata_out, exp_rd);
      check("tx_valid", bus.tx_valid_out, tx_q.size() != 0);
      if (tx_q.size() != 0) check("tx_data", bus.tx_data_out, tx_q[0]);
      check("rx_ready", bus.rx_ready_out, rx_q.size() < 16);
      check("io_buffer_full", bus.io_buffer_full_out, tx_q.size() >= 14);
      check("program_stop", bus.program_stop_out, m_stop);
      check("tx_overflow", bus.tx_overflow_out, m_ovf);
    end
  end

  // Driver: one CPU access sampled at the next edge, then the bus returns to an
  // idle unmapped read.
  task automatic bus_op(input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus.mem_a_in = a; bus.mem_wr_in = wr; bus.mem_wdata_in = d;
    @(posedge clk); #1;
    bus.mem_a_in = 32'h0002_0000; bus.mem_wr_in = 1'b0; bus.mem_wdata_in = 8'h00;
  endtask

  task automatic rx_push(input logic [7:0] d);
    bus.rx_valid_in = 1'b1; bus.rx_data_in = d;
    @(posedge clk); #1;
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdata"},  bus.mem_rdata_out, 8'h00);
    check({tag, "_txv"},    bus.tx_valid_out, 1'b0);
    check({tag, "_rxr"},    bus.rx_ready_out, 1'b1);
    check({tag, "_iobuf"},  bus.io_buffer_full_out, 1'b0);
    check({tag, "_stop"},   bus.program_stop_out, 1'b0);
    check({tag, "_ovf"},    bus.tx_overflow_out, 1'b0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int pops;
    logic [31:0] ra;
    bit tx_busy;
    bus.mem_a_in = 32'h0002_0000; bus.mem_wr_in = 1'b0; bus.mem_wdata_in = 8'h00;
    bus.rx_valid_in = 1'b0; bus.rx_data_in = 8'h00; bus.tx_ready_in = 1'b0;

    // Reset state
    #23;
    check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1; chk_on = 1'b1;
    @(posedge clk); #1;

    // Counter snapshot: counter byte then frozen upper bytes
    guard = 0;
    while (m_cnt != 32'hFF && guard < 1000) begin @(posedge clk); #1; guard++; end
    check("counter_wait", guard < 1000, 1'b1);
    bus_op(32'h0003_0004, 1'b0, 8'h00); check("cnt_b0", bus.mem_rdata_out, 8'hFF);
    bus_op(32'h0003_0005, 1'b0, 8'h00); check("cnt_b1", bus.mem_rdata_out, 8'h00);
    bus_op(32'h0003_0006, 1'b0, 8'h00); check("cnt_b2", bus.mem_rdata_out, 8'h00);
    bus_op(32'h0003_0007, 1'b0, 8'h00); check("cnt_b3", bus.mem_rdata_out, 8'h00);

    // RAM write then read the next cycle
    bus_op(32'h0000_0100, 1'b1, 8'hA5);
    bus_op(32'h0000_0100, 1'b0, 8'h00); check("ram_a5", bus.mem_rdata_out, 8'hA5);

    // Unmapped window
    bus_op(32'h0000_0010, 1'b1, 8'h3C);
    bus_op(32'h0002_0010, 1'b0, 8'h00); check("unmapped_rd", bus.mem_rdata_out, 8'h00);
    bus_op(32'h0002_0010, 1'b1, 8'h77);
    bus_op(32'h0000_0010, 1'b0, 8'h00); check("unmapped_wr_no_alias", bus.mem_rdata_out, 8'h3C);

    // RX FIFO pops through the data port
    rx_push(8'h41);
    rx_push(8'h42);
    check("rx_ready_hold", bus.rx_ready_out, 1'b1);
    bus_op(32'h0003_0000, 1'b0, 8'h00); check("rx_pop1", bus.mem_rdata_out, 8'h41);
    bus_op(32'h0003_0000, 1'b0, 8'h00); check("rx_pop2", bus.mem_rdata_out, 8'h42);
    bus_op(32'h0003_0000, 1'b0, 8'h00); check("rx_empty", bus.mem_rdata_out, 8'h00);

    // TX fill, near-full flag, zero write ignored, overflow, drain
    bus.tx_ready_in = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus_op(32'h0003_0000, 1'b1, 8'h31);
      if (i == 12) check("iobuf_13", bus.io_buffer_full_out, 1'b0);
    end
    check("iobuf_14", bus.io_buffer_full_out, 1'b1);
    bus_op(32'h0003_0000, 1'b1, 8'h00);
    bus_op(32'h0003_0000, 1'b1, 8'h31);
    bus_op(32'h0003_0000, 1'b1, 8'h31);
    check("ovf_before", bus.tx_overflow_out, 1'b0);
    bus_op(32'h0003_0000, 1'b1, 8'h31);
    check("ovf_after", bus.tx_overflow_out, 1'b1);
    bus.tx_ready_in = 1'b1;
    pops = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.tx_valid_out) begin
        check("tx_drain_byte", bus.tx_data_out, 8'h31);
        pops++;
      end
    end
    @(posedge clk); #1;
    bus.tx_ready_in = 1'b0;
    check("tx_drain_count", pops, 16);
    check("iobuf_drained", bus.io_buffer_full_out, 1'b0);

    // Program stop, then asynchronous reset mid-operation
    bus_op(32'h0003_0004, 1'b1, 8'h99);
    check("stop_set", bus.program_stop_out, 1'b1);
    check("stop_txv", bus.tx_valid_out, 1'b1);
    check("stop_txd", bus.tx_data_out, 8'h00);
    bus.mem_a_in = 32'h0003_0000; bus.mem_wr_in = 1'b1; bus.mem_wdata_in = 8'h55;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    bus.mem_a_in = 32'h0002_0000; bus.mem_wr_in = 1'b0; bus.mem_wdata_in = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus_op(32'h0000_0100, 1'b0, 8'h00); check("ram_survives_reset", bus.mem_rdata_out, 8'hA5);

    // Random traffic against the model
    tx_busy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) tx_busy = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0, 1, 2: ra = 32'h0000_0100 + 32'($urandom_range(0, 15));
        3:       ra = 32'h0001_FFFF;
        4:       ra = 32'h0002_0000 + 32'($urandom_range(0, 16'hFFFF));
        default: ra = 32'h0003_0000 + 32'($urandom_range(0, 7));
      endcase
      ra[31:18] = 14'($urandom);
      bus.mem_a_in     = ra;
      bus.mem_wr_in    = ($urandom_range(0, 2) == 0);
      bus.mem_wdata_in = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      bus.rx_valid_in  = ($urandom_range(0, 2) != 0);
      bus.rx_data_in   = 8'($urandom);
      bus.tx_ready_in  = tx_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.mem_a_in = 32'h0002_0000; bus.mem_wr_in = 1'b0;
    bus.rx_valid_in = 1'b0; bus.tx_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
